// File: rtl/vga_sync_module_if.sv
// Raster output bundle from vga_sync_module to the pixel-colour logic.
// master drives the timing; slave consumes it.
interface vga_sync_module_if;
  logic       h_sync;
  logic       v_sync;
  logic       video_on;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  modport master (output h_sync, v_sync, video_on, pos_x, pos_y);
  modport slave  (input  h_sync, v_sync, video_on, pos_x, pos_y);
endinterface

// File: rtl/vga_sync_module.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered sync/video_on.
// Optional build macro VGA_SYNC_ACTIVE_HIGH_EN inverts both sync outputs (active high).
module vga_sync_module #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 4
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_module_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_IDLE = 1'b0;
`else
  localparam logic SYNC_IDLE = 1'b1;
`endif

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_h_sync;
  logic             r_v_sync;
  logic             r_video_on;

  logic             w_tick;
  logic             w_h_wrap;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_h_in_sync;
  logic             w_v_in_sync;
  logic             w_visible;

  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_h_wrap = (r_h_cnt == H_LAST);

  always_comb begin
    w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  // Decode from the next counter values so the registered flags line up with pos_x/pos_y
  assign w_h_in_sync = ({1'b0, w_h_next} >= H_SYNC_BEG) && ({1'b0, w_h_next} < H_SYNC_END);
  assign w_v_in_sync = ({1'b0, w_v_next} >= V_SYNC_BEG) && ({1'b0, w_v_next} < V_SYNC_END);
  assign w_visible   = ({1'b0, w_h_next} < H_ACT_END) && ({1'b0, w_v_next} < V_ACT_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_h_sync   <= SYNC_IDLE;
      r_v_sync   <= SYNC_IDLE;
      r_video_on <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_h_cnt    <= w_h_next;
        r_v_cnt    <= w_v_next;
        r_h_sync   <= w_h_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
        r_v_sync   <= w_v_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
        r_video_on <= w_visible;
      end
    end
  end

  assign vga.pos_x    = r_h_cnt;
  assign vga.pos_y    = r_v_cnt;
  assign vga.h_sync   = r_h_sync;
  assign vga.v_sync   = r_v_sync;
  assign vga.video_on = r_video_on;
endmodule

// File: tb/tb_vga_sync_module.sv
// Bench for vga_sync_module: default, reduced and PIX_DIV=1 instances checked every cycle
// against a tick-count raster model; random async resets. Honours VGA_SYNC_ACTIVE_HIGH_EN.
module tb_vga_sync_module;
  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_IDLE = 1'b0;
`else
  localparam logic SYNC_IDLE = 1'b1;
`endif

  logic clk;
  logic rst;
  int   n_edges;
  int   n_checks;
  int   n_errors;

  vga_sync_module_if if_d ();
  vga_sync_module_if if_s ();
  vga_sync_module_if if_1 ();

  vga_sync_module u_dut_dflt (
    .clk   (clk),
    .reset (rst),
    .vga   (if_d)
  );

  vga_sync_module #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .PIX_DIV  (3)
  ) u_dut_small (
    .clk   (clk),
    .reset (rst),
    .vga   (if_s)
  );

  vga_sync_module #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .PIX_DIV  (1)
  ) u_dut_div1 (
    .clk   (clk),
    .reset (rst),
    .vga   (if_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset last released; every model value derives from this
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t edges=%0d)", tag, got, exp, $time, n_edges);
    end
  endtask

  task automatic check_dut(input string name, input int pdiv,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic hsy, input logic vsy, input logic von);
    int   ht, vt, t, ex, ey;
    logic ehs, evs, evon;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    t    = n_edges / pdiv;
    ex   = t % ht;
    ey   = (t / ht) % vt;
    evon = (t != 0) && (ex < ha) && (ey < va);
    ehs  = (ex >= ha + hf && ex < ha + hf + hs) ? ~SYNC_IDLE : SYNC_IDLE;
    evs  = (ey >= va + vf && ey < va + vf + vs) ? ~SYNC_IDLE : SYNC_IDLE;
    chk({name, ".pos_x"},    int'(x),   ex);
    chk({name, ".pos_y"},    int'(y),   ey);
    chk({name, ".h_sync"},   int'(hsy), int'(ehs));
    chk({name, ".v_sync"},   int'(vsy), int'(evs));
    chk({name, ".video_on"}, int'(von), int'(evon));
  endtask

  task automatic check_all();
    check_dut("dflt", 4, 640, 16, 96, 48, 480, 10, 2, 33,
              if_d.pos_x, if_d.pos_y, if_d.h_sync, if_d.v_sync, if_d.video_on);
    check_dut("small", 3, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
              if_s.pos_x, if_s.pos_y, if_s.h_sync, if_s.v_sync, if_s.video_on);
    check_dut("div1", 1, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
              if_1.pos_x, if_1.pos_y, if_1.h_sync, if_1.v_sync, if_1.video_on);
  endtask

  always @(negedge clk) check_all();

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    // Long enough for a full default line plus several reduced frames
    repeat (4000) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(20, 1500)) @(negedge clk);
      #($urandom_range(1, 3)) rst = 1'b1;
      #1 check_all();
      repeat (10) @(negedge clk);
      #1 rst = 1'b0;
    end
    repeat (4000) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_sync_module.md
# vga_sync_module

Raster timing generator for a VGA display port, 640x480 @ 60 Hz by default. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. From those counters it produces the h_sync and v_sync pulses, a video_on (active-area) flag, and the current pixel coordinates. It sits between the board clock/reset and the pixel-colour logic, which uses pos_x/pos_y and video_on to drive RGB.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 4, system clocks per pixel (≥1); 100 MHz -> 25 MHz

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- h_sync  output  1  horizontal sync, active low
- v_sync  output  1  vertical sync, active low
- video_on  output  1  high while the current pixel is in the visible area
- pos_x  output  10  current horizontal count, 0..H_TOTAL-1
- pos_y  output  10  current vertical count, 0..V_TOTAL-1

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be ≤1024.
- Divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - tick is high for one clk cycle when div_cnt == PIX_DIV-1.
  - With PIX_DIV=1, tick is permanently high.
- Horizontal counter: on tick, h_cnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on a tick where h_cnt wraps; at V_TOTAL-1 it wraps to 0, together with h_cnt.
- Coordinates: pos_x = h_cnt, pos_y = v_cnt, driven directly from the registers.
- Sync decode:
  - h_sync is low while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - v_sync is low while V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- h_sync, v_sync and video_on are registered. They are computed from the next counter values, so they stay cycle-aligned with pos_x/pos_y and are glitch-free.
- Between ticks, all outputs hold.

## Timing
- Reset values: div_cnt=0, pos_x=0, pos_y=0, h_sync=1, v_sync=1, video_on=0.
- Reset is asynchronous: outputs take their reset values immediately, whatever phase the raster is in, and the raster restarts from (0,0).
- First tick falls on the PIX_DIV-th rising clk edge after reset deasserts. On that edge pos_x becomes 1 and video_on becomes 1.
- Pixel (0,0) of the first frame after reset is therefore blanked. In every later frame, (0,0) has video_on=1.
- All outputs change only on a rising clk edge where tick is high.
- Line period = H_TOTAL ticks; frame period = H_TOTAL*V_TOTAL ticks (default 420000 ticks = 1 680 000 clk).
- Line wrap: on the tick where pos_x goes 799->0, pos_y increments on the same edge.
- Frame wrap: on the tick where (799,524) -> (0,0), both counters wrap on the same edge.

## Configuration
- VGA_SYNC_ACTIVE_HIGH_EN
  - Undefined (default): h_sync and v_sync are active low and idle/reset high.
  - Defined: both syncs are inverted (active high, idle/reset low).
- Counters, video_on and timing are identical in both builds.

## Test plan
- Reset:
  - Assert reset mid-line at (300,200), async and without a clk edge -> pos_x=0, pos_y=0, h_sync=1, v_sync=1, video_on=0 immediately.
  - Hold reset 10 clk -> no change.
- Divider: release reset with PIX_DIV=4 -> pos_x stays 0 for 3 edges, becomes 1 on the 4th edge, then 2 on the 8th edge.
- Horizontal:
  - Run one line -> h_sync low for exactly 96 ticks starting at pos_x=656.
  - video_on low for pos_x 640..799.
  - pos_x 799->0 with pos_y incrementing on the same edge.
- Vertical/frame:
  - Run a full frame -> v_sync low for exactly 2 lines (pos_y 490, 491).
  - video_on never high for pos_y ≥480.
  - Wrap (799,524)->(0,0) after 420000 ticks.
- Second frame: at pos (0,0) after the first wrap -> video_on=1, h_sync=1, v_sync=1.
- Macro build: define VGA_SYNC_ACTIVE_HIGH_EN -> h_sync=0 out of reset, h_sync high only for pos_x 656..751.
